// File: rtl/mips_mc_control.sv
// Multi-cycle main control FSM for the MIPS core: sequences fetch/decode/execute/memory/writeback.
// Optional PERF_CNT_EN builds cycle and retired-instruction counters; otherwise both read as 0.
module mips_mc_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [2:0]       alu_op,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  state_e state_q, state_d;

  function automatic logic funct_legal(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLL);
  endfunction

  function automatic logic [2:0] funct_alu_op(input logic [5:0] f);
    logic [2:0] op;
    case (f)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLL:  op = ALU_SLL;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Moore decode with mem_ready/zero qualifiers; everything defaults to 0.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    alu_op     = ALU_AND;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE:     state_d = funct_legal(funct) ? S_EXEC : S_TRAP;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = funct_alu_op(funct);
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_source  = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_TRAP;
    endcase

    // No architectural write may fire while reset is held, even with mem_ready high in FETCH.
    if (!rst_n) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign state = state_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      instr_cnt_q <= instr_cnt_q + CNT_W'(instr_done);
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: directed per-cycle vectors queued by stimulus, checked by a monitor.
module tb_mips_mc_control;

  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic instr_done, illegal;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  mips_mc_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op), .state(state),
    .instr_done(instr_done), .illegal(illegal), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       st;
    logic             pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa;
    logic [1:0]       asb, pcs;
    logic [2:0]       aop;
    logic             done, ill;
    logic [CNT_W-1:0] cyc, ins;
  } outs_t;

  typedef struct {
    outs_t exp;
    string tag;
  } item_t;

  item_t sb_q[$];
  int n_vec = 0;
  int n_bad = 0;
  logic [CNT_W-1:0] m_cyc = '0, m_ins = '0;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000, OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR = 6'b100101, FN_SLL = 6'b000000;

  // Output table written from the state descriptions.
  function automatic outs_t spec_out(input logic rst, input logic [3:0] st, input logic mr,
                                     input logic z, input logic [5:0] fn);
    outs_t o = '0;
    o.st = st;
    case (st)
      4'd0:  begin o.mrd = 1; o.asb = 2'b01; o.aop = 3'b010; o.irw = mr & rst; o.pcw = mr & rst; end
      4'd1:  begin o.asb = 2'b11; o.aop = 3'b010; end
      4'd2:  begin o.asa = 1; o.asb = 2'b10; o.aop = 3'b010; end
      4'd3:  begin o.mrd = 1; o.iord = 1; end
      4'd4:  begin o.rw = 1; o.m2r = 1; o.done = 1; end
      4'd5:  begin o.mwr = 1; o.iord = 1; o.done = mr; end
      4'd6:  begin
        o.asa = 1;
        case (fn)
          FN_ADD: o.aop = 3'b010;
          FN_SUB: o.aop = 3'b110;
          FN_AND: o.aop = 3'b000;
          FN_OR:  o.aop = 3'b001;
          default: o.aop = 3'b111;
        endcase
      end
      4'd7:  begin o.rw = 1; o.rdst = 1; o.done = 1; end
      4'd8:  begin o.asa = 1; o.aop = 3'b110; o.pcs = 2'b01; o.pcw = z; o.done = 1; end
      4'd9:  begin o.pcs = 2'b10; o.pcw = 1; o.done = 1; end
      4'd10: begin o.asa = 1; o.asb = 2'b10; o.aop = 3'b010; end
      4'd11: begin o.rw = 1; o.done = 1; end
      4'd12: o.ill = 1;
      default: ;
    endcase
    return o;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input logic rst, input logic [3:0] st, input logic mr, input logic z,
                      input logic [5:0] op, input logic [5:0] fn, input string tag);
    item_t it;
    rst_n = rst; mem_ready = mr; zero = z; opcode = op; funct = fn;
    if (!rst) begin m_cyc = '0; m_ins = '0; end
    it.exp = spec_out(rst, st, mr, z, fn);
`ifdef PERF_CNT_EN
    it.exp.cyc = m_cyc;
    it.exp.ins = m_ins;
`endif
    it.tag = tag;
    sb_q.push_back(it);
    if (rst) begin
      m_cyc = m_cyc + CNT_W'(1);
      m_ins = m_ins + CNT_W'(it.exp.done);
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      item_t it;
      outs_t act;
      it = sb_q.pop_front();
      act = '{st: state, pcw: pc_write, iord: iord, mrd: mem_read, mwr: mem_write, irw: ir_write,
              rdst: reg_dst, m2r: mem_to_reg, rw: reg_write, asa: alu_src_a, asb: alu_src_b,
              pcs: pc_source, aop: alu_op, done: instr_done, ill: illegal,
              cyc: cycle_cnt, ins: instr_cnt};
      n_vec++;
      if (act !== it.exp) begin
        n_bad++;
        $display("FAIL %s vec%0d: got %h expected %h (state got %0d exp %0d)",
                 it.tag, n_vec, act, it.exp, act.st, it.exp.st);
      end
    end
  end

  logic [5:0] fns [4] = '{FN_ADD, FN_AND, FN_OR, FN_SLL};

  initial begin
    @(posedge clk); #1;
    step(0, 0, 1, 0, OP_R, FN_SUB, "reset");
    step(0, 0, 1, 0, OP_R, FN_SUB, "reset_hold");
    repeat (3) step(1, 0, 0, 0, OP_R, FN_SUB, "fetch_wait");
    step(1, 0, 1, 0, OP_R, FN_SUB, "fetch_go");
    step(1, 1, 1, 0, OP_R, FN_SUB, "sub_decode");
    step(1, 6, 1, 0, OP_R, FN_SUB, "sub_exec");
    step(1, 7, 1, 0, OP_R, FN_SUB, "sub_wb");
    foreach (fns[i]) begin
      step(1, 0, 1, 0, OP_R, fns[i], "rtype_fetch");
      step(1, 1, 1, 0, OP_R, fns[i], "rtype_decode");
      step(1, 6, 1, 0, OP_R, fns[i], "rtype_exec");
      step(1, 7, 1, 0, OP_R, fns[i], "rtype_wb");
    end
    step(1, 0, 1, 0, OP_LW, 6'h00, "lw_fetch");
    step(1, 1, 1, 0, OP_LW, 6'h00, "lw_decode");
    step(1, 2, 1, 0, OP_LW, 6'h00, "lw_memadr");
    step(1, 3, 0, 0, OP_LW, 6'h00, "lw_wait1");
    step(1, 3, 0, 0, OP_LW, 6'h00, "lw_wait2");
    step(1, 3, 1, 0, OP_LW, 6'h00, "lw_memrd");
    step(1, 4, 1, 0, OP_LW, 6'h00, "lw_memwb");
    step(1, 0, 1, 0, OP_SW, 6'h00, "sw_fetch");
    step(1, 1, 1, 0, OP_SW, 6'h00, "sw_decode");
    step(1, 2, 1, 0, OP_SW, 6'h00, "sw_memadr");
    step(1, 5, 0, 0, OP_SW, 6'h00, "sw_wait");
    step(1, 5, 1, 0, OP_SW, 6'h00, "sw_memwr");
    step(1, 0, 1, 1, OP_BEQ, 6'h00, "beq1_fetch");
    step(1, 1, 1, 1, OP_BEQ, 6'h00, "beq1_decode");
    step(1, 8, 1, 1, OP_BEQ, 6'h00, "beq_taken");
    step(1, 0, 1, 0, OP_BEQ, 6'h00, "beq0_fetch");
    step(1, 1, 1, 0, OP_BEQ, 6'h00, "beq0_decode");
    step(1, 8, 1, 0, OP_BEQ, 6'h00, "beq_not_taken");
    step(1, 0, 1, 0, OP_J, 6'h00, "j_fetch");
    step(1, 1, 1, 0, OP_J, 6'h00, "j_decode");
    step(1, 9, 1, 0, OP_J, 6'h00, "j_jump");
    step(1, 0, 1, 0, OP_ADDI, 6'h00, "addi_fetch");
    step(1, 1, 1, 0, OP_ADDI, 6'h00, "addi_decode");
    step(1, 10, 1, 0, OP_ADDI, 6'h00, "addi_ex");
    step(1, 11, 1, 0, OP_ADDI, 6'h00, "addi_wb");
    step(1, 0, 1, 0, OP_R, 6'b000001, "badfn_fetch");
    step(1, 1, 1, 0, OP_R, 6'b000001, "badfn_decode");
    repeat (3) step(1, 12, 1, 0, OP_R, 6'b000001, "badfn_trap");
    step(0, 0, 1, 0, OP_BAD, 6'h00, "badfn_reset");
    step(1, 0, 1, 0, OP_BAD, 6'h00, "badop_fetch");
    step(1, 1, 1, 0, OP_BAD, 6'h00, "badop_decode");
    repeat (20) step(1, 12, 1, 0, OP_BAD, 6'h00, "badop_trap");
    step(0, 0, 1, 0, OP_BAD, 6'h00, "trap_reset");
    step(1, 0, 0, 0, OP_SW, 6'h00, "trap_cleared");
    step(0, 0, 1, 0, OP_SW, 6'h00, "cnt_reset");
    step(1, 0, 1, 0, OP_SW, 6'h00, "cnt_sw_fetch");
    step(1, 1, 1, 0, OP_SW, 6'h00, "cnt_sw_decode");
    step(1, 2, 1, 0, OP_SW, 6'h00, "cnt_sw_memadr");
    step(1, 5, 1, 0, OP_SW, 6'h00, "cnt_sw_memwr");
    step(1, 0, 1, 0, OP_J, 6'h00, "cnt_j_fetch");
    step(1, 1, 1, 0, OP_J, 6'h00, "cnt_j_decode");
    step(1, 9, 1, 0, OP_J, 6'h00, "cnt_j_jump");
    step(1, 0, 1, 0, OP_ADDI, 6'h00, "cnt_addi_fetch");
    step(1, 1, 1, 0, OP_ADDI, 6'h00, "cnt_addi_decode");
    step(1, 10, 1, 0, OP_ADDI, 6'h00, "cnt_addi_ex");
    step(1, 11, 1, 0, OP_ADDI, 6'h00, "cnt_addi_wb");
    step(1, 0, 0, 0, OP_ADDI, 6'h00, "cnt_check");
    step(1, 0, 1, 0, OP_ADDI, 6'h00, "mid_fetch");
    step(1, 1, 1, 0, OP_ADDI, 6'h00, "mid_decode");
    step(1, 10, 1, 0, OP_ADDI, 6'h00, "mid_ex");
    step(0, 0, 1, 0, OP_ADDI, 6'h00, "mid_reset");
    step(1, 0, 0, 0, OP_ADDI, 6'h00, "mid_release");
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle main control FSM for the MIPS core.
- Sequences the shared 32-bit datapath across fetch, decode, execute, memory and writeback: PC, instruction register, register file, unified memory port and the single ALU.
- Decodes opcode/funct into the 3-bit ALU operation code.
- Stalls on a memory ready handshake; traps on illegal instructions.

Parameters:
- CNT_W, 32, width of the performance counters (used only with PERF_CNT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  load PC.
- iord  out  1  0 = memory address from PC, 1 = from ALU result register.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load IR.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = MDR, 0 = ALU result register.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- pc_source  out  2  00 = ALU out, 01 = ALU result register, 10 = jump target.
- alu_op  out  3  010 add, 110 sub, 000 and, 001 or, 111 shift-left.
- state  out  4  current state, for debug.
- instr_done  out  1  one-cycle pulse on instruction retire.
- illegal  out  1  sticky trap flag.
- cycle_cnt  out  CNT_W  cycle counter.
- instr_cnt  out  CNT_W  retired instruction counter.

Behaviour:
- State register is asynchronously reset by rst_n low to FETCH (0).
  - All outputs are 0 at reset except the FETCH defaults below.
  - illegal = 0, both counters = 0.
- Outputs are Moore (decoded from state), except the mem_ready and zero qualifiers noted per state. Any output not listed for a state is 0.
- Supported instructions:
  - R-type (opcode 000000), funct 100000 add, 100010 sub, 100100 and, 100101 or, 000000 sll.
  - lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States, with encoding, outputs and transitions:
  - FETCH(0): mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 010, pc_source = 00; ir_write = pc_write = mem_ready. Stays in FETCH while mem_ready = 0, else goes to DECODE.
  - DECODE(1): alu_src_a = 0, alu_src_b = 11, alu_op = 010 (branch target). Goes to MEMADR for lw/sw, EXEC for R-type with a legal funct, BRANCH for beq, JUMP for j, ADDIEX for addi, TRAP otherwise.
  - MEMADR(2): alu_src_a = 1, alu_src_b = 10, alu_op = 010. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD(3): mem_read = 1, iord = 1. Holds until mem_ready, then goes to MEMWB.
  - MEMWB(4): reg_write = 1, mem_to_reg = 1, reg_dst = 0, instr_done = 1. Goes to FETCH.
  - MEMWR(5): mem_write = 1, iord = 1. Holds until mem_ready; on mem_ready, instr_done = 1 and goes to FETCH.
  - EXEC(6): alu_src_a = 1, alu_src_b = 00, alu_op from funct. Goes to ALUWB.
  - ALUWB(7): reg_write = 1, reg_dst = 1, mem_to_reg = 0, instr_done = 1. Goes to FETCH.
  - BRANCH(8): alu_src_a = 1, alu_src_b = 00, alu_op = 110, pc_source = 01, pc_write = zero, instr_done = 1. Goes to FETCH.
  - JUMP(9): pc_source = 10, pc_write = 1, instr_done = 1. Goes to FETCH.
  - ADDIEX(10): alu_src_a = 1, alu_src_b = 10, alu_op = 010. Goes to ADDIWB.
  - ADDIWB(11): reg_write = 1, reg_dst = 0, mem_to_reg = 0, instr_done = 1. Goes to FETCH.
  - TRAP(12): illegal = 1, all enables 0. Absorbing; exits only on reset.
- Encodings 13–15: next state TRAP.
- mem_read and mem_write are never high in the same cycle.
- Memory requests are held stable while mem_ready = 0.
- Reset asserted mid-instruction: immediate return to FETCH; no write enable is asserted in the reset cycle.
- Latencies with zero memory wait:
  - lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
  - Each memory wait cycle adds 1.

Optional Feature:
- PERF_CNT_EN defined:
  - cycle_cnt increments every cycle out of reset, including in TRAP.
  - instr_cnt increments on instr_done.
  - Both wrap modulo 2^CNT_W.
- PERF_CNT_EN undefined: cycle_cnt and instr_cnt are tied to 0 and no counter flops are built.

Test Plan:
- Reset, then hold mem_ready = 0 for 3 cycles -> state = 0, mem_read = 1, ir_write = 0, pc_write = 0; on the first mem_ready = 1 cycle ir_write = pc_write = 1.
- R-type sub (funct 100010), mem_ready = 1 -> states 0,1,6,7; alu_op = 110 in EXEC; reg_write = 1 and reg_dst = 1 in ALUWB; instr_done pulses once.
- lw with 2 wait cycles in MEMRD -> 7 total cycles; iord = 1 for 3 cycles; reg_write = 1 and mem_to_reg = 1 in MEMWB.
- beq with zero = 1 and then zero = 0 -> pc_write = 1 and 0 respectively in BRANCH; pc_source = 01; 3 cycles each.
- Opcode 111111 -> TRAP with illegal = 1 held for 20 cycles; rst_n pulse -> illegal = 0, state = 0.
- PERF_CNT_EN defined, run sw, j, addi back-to-back, zero wait -> instr_cnt = 3, cycle_cnt = 11; rst_n low mid-addi clears both counters to 0.
